mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer built as a binary tree of 2:1 selection levels, with one register stage per level and a valid/ready handshake. It is the successor to the combinational 8:1 tree mux. Wide selection paths (bus arbiters, debug/observation muxes) use it where a single-cycle tree does not meet timing. The block accepts one select-plus-data item per cycle, propagates it down the tree and presents one selected word per cycle after a fixed latency. A downstream stall freezes the whole pipe.

## Interface
- N_IN, default 8: number of input channels. Must be a power of 2 and ≥ 2.
- DW, default 1: width of each channel in bits.
- SEL_W, derived as log2(N_IN): select width and number of pipeline levels (L = SEL_W). Do not override.

- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_data, input, N_IN*DW: channel c occupies bits [c*DW +: DW].
- in_sel, input, SEL_W: channel index to select.
- in_valid, input, 1: in_data/in_sel carry an item.
- in_ready, output, 1: the pipe accepts an item this cycle.
- out_data, output, DW: selected channel word.
- out_valid, output, 1: out_data holds a completed item.
- out_ready, input, 1: downstream consumes out_data this cycle.

## Operation
- Tree ordering:
  - Level k (k = 1..L) uses select bit k-1.
  - sel[0] chooses within adjacent pairs. sel[L-1] chooses between the lower and upper halves.
  - Result equals in_data[in_sel*DW +: DW].
- Stage k registers:
  - N_IN/2^k words of DW bits.
  - The unused select bits sel[L-1:k].
  - One valid bit.
- Stage k word j = stage(k-1) word (2j + sel[k-1]). Stage 0 is the input bus.
- Global advance enable: adv = !out_valid || out_ready.
  - When adv = 1, every stage loads from its predecessor. Stage 1 loads from the inputs, with valid_1 <= in_valid.
  - When adv = 0, every stage, including its valid bit, holds.
- in_ready = adv (combinational from out_valid/out_ready only; no path from in_valid).
- Bubbles (valid = 0) travel down the pipe like items and are never emitted: out_valid = valid_L.
- out_data = stage L word 0, registered. No combinational path from inputs to outputs.
- Handshake:
  - An item is accepted when in_valid && in_ready.
  - An item is delivered when out_valid && out_ready.
  - out_data and out_valid stay stable while out_valid && !out_ready.
- Data/select registers may load on adv regardless of valid. Their content is don't-care when the matching valid is 0.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, all data and select registers 0.
  - Outputs during and after reset: out_valid = 0, out_data = 0, in_ready = 1.
- Reset released mid-operation: all in-flight items are discarded. No partial item is ever emitted.
- Latency: an item accepted at edge t appears with out_valid = 1 after edge t+L-1. It is visible in the cycle following the Lth edge, so latency is L cycles (8 channels: 3 cycles).
- Throughput: 1 item/cycle while out_ready stays high.
- Stall: when out_ready is low with out_valid = 1, in_ready goes low in the same cycle. No item is accepted or lost. Throughput resumes in the cycle after out_ready returns high.
- Simultaneous events:
  - Delivery and acceptance in the same cycle are allowed: out_ready high gives adv = 1.
  - When out_valid = 0, in_ready is high even if out_ready is low, so the pipe fills.
- N_IN = 2: L = 1, single register stage, latency 1.

## Test plan
- Reset, then N_IN=8, DW=8, in_data = {8'h77,8'h66,...,8'h00}, with in_sel sweeping 0..7 on consecutive cycles and out_ready=1 → out_data = 8'h00..8'h77 in order, first word 3 cycles after the first accept, no gaps.
- Boundary selects: in_sel=0 and in_sel=7 with in_data = 64'h8000_0000_0000_0001 → out_data 8'h01, then 8'h80.
- Stall: stream 6 items and hold out_ready=0 for 4 cycles mid-stream → out_data/out_valid frozen, in_ready=0 during the stall, all 6 items delivered exactly once and in order.
- Bubbles: in_valid pattern 1,0,1,0,0,1 → out_valid pattern is identical, delayed 3 cycles, with the matching data.
- Async reset: assert rst_n=0 between clock edges with 3 items in flight → out_valid=0 and out_data=0 immediately. After release, no stale item appears and a new item (sel=5) emerges after 3 cycles.
- Parameter sweep: N_IN=2/DW=1 (latency 1) and N_IN=32/DW=4 (latency 5), with random stimulus checked against the reference model in_data[in_sel*DW +: DW].

Source files
------------

// File: rtl/mux_tree_pipe.sv
// ============================================================================
// Module   : mux_tree_pipe
// Purpose  : Pipelined N:1 binary-tree multiplexer with one register stage per
//            select bit and a valid/ready handshake. A stall freezes the pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_tree_pipe #(
    parameter int N_IN  = 8,
    parameter int DW    = 1,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_IN*DW-1:0]   in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic              w_adv;
    logic [2*DW-1:0]   w_last_src_data;
    logic              w_last_src_sel;
    logic              w_last_src_valid;
    logic [DW-1:0]     r_out_data;
    logic              r_out_valid;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Stages 1..L-1 carry the select bits not yet consumed; the last stage
    // needs none and is built separately below.
    for (genvar k = 1; k < SEL_W; k++) begin : g_stage
        localparam int c_src_words = N_IN >> (k - 1);
        localparam int c_dst_words = N_IN >> k;
        localparam int c_sel_w     = SEL_W - k;

        logic [c_src_words*DW-1:0] w_src_data;
        logic [c_sel_w:0]          w_src_sel;
        logic                      w_src_valid;
        logic [c_dst_words*DW-1:0] w_next_data;
        logic [c_dst_words*DW-1:0] r_data;
        logic [c_sel_w-1:0]        r_sel;
        logic                      r_valid;

        if (k == 1) begin : g_src_input
            assign w_src_data  = in_data;
            assign w_src_sel   = in_sel;
            assign w_src_valid = in_valid;
        end else begin : g_src_stage
            assign w_src_data  = g_stage[k-1].r_data;
            assign w_src_sel   = g_stage[k-1].r_sel;
            assign w_src_valid = g_stage[k-1].r_valid;
        end

        for (genvar j = 0; j < c_dst_words; j++) begin : g_word
            assign w_next_data[j*DW +: DW] = w_src_sel[0] ? w_src_data[(2*j+1)*DW +: DW]
                                                           : w_src_data[(2*j)*DW +: DW];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_sel   <= '0;
                r_valid <= 1'b0;
            end else if (w_adv) begin
                r_data  <= w_next_data;
                r_sel   <= w_src_sel[c_sel_w:1];
                r_valid <= w_src_valid;
            end
        end
    end

    if (SEL_W == 1) begin : g_last_src_input
        assign w_last_src_data  = in_data;
        assign w_last_src_sel   = in_sel[0];
        assign w_last_src_valid = in_valid;
    end else begin : g_last_src_stage
        assign w_last_src_data  = g_stage[SEL_W-1].r_data;
        assign w_last_src_sel   = g_stage[SEL_W-1].r_sel[0];
        assign w_last_src_valid = g_stage[SEL_W-1].r_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_data  <= w_last_src_sel ? w_last_src_data[DW +: DW] : w_last_src_data[0 +: DW];
            r_out_valid <= w_last_src_valid;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
// ============================================================================
// Module   : tb_mux_tree_pipe
// Purpose  : Self-checking bench for mux_tree_pipe at 8x8, 2x1 and 32x4 using a
//            queue-based reference model with stall-aware latency checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [63:0]  a_in_data;  logic [2:0] a_in_sel;  logic a_in_valid, a_in_ready;
    logic [7:0]   a_out_data; logic a_out_valid, a_out_ready;
    logic [1:0]   b_in_data;  logic [0:0] b_in_sel;  logic b_in_valid, b_in_ready;
    logic [0:0]   b_out_data; logic b_out_valid, b_out_ready;
    logic [127:0] c_in_data;  logic [4:0] c_in_sel;  logic c_in_valid, c_in_ready;
    logic [3:0]   c_out_data; logic c_out_valid, c_out_ready;

    mux_tree_pipe #(.N_IN(8), .DW(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready));
    mux_tree_pipe #(.N_IN(2), .DW(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready));
    mux_tree_pipe #(.N_IN(32), .DW(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_sel(c_in_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready));

    typedef struct {
        logic [7:0] data;
        int         cyc;
        int         stalls;
    } item_t;

    item_t      q_a[$], q_b[$], q_c[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc[3];
    int         stalls[3];
    logic       hold[3];
    logic [7:0] hold_data[3];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the selected channel is simply the DW-bit slice at sel*DW.
    function automatic logic [7:0] ref_sel(input logic [127:0] din, input int sel, input int dw);
        logic [127:0] t;
        logic [7:0]   m;
        t = din >> (sel * dw);
        m = (8'd1 << dw) - 8'd1;
        return t[7:0] & m;
    endfunction

    function automatic int q_size(input int id);
        case (id)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    function automatic item_t q_front(input int id);
        case (id)
            0:       return q_a[0];
            1:       return q_b[0];
            default: return q_c[0];
        endcase
    endfunction

    task automatic q_push(input int id, input item_t it);
        case (id)
            0:       q_a.push_back(it);
            1:       q_b.push_back(it);
            default: q_c.push_back(it);
        endcase
    endtask

    task automatic q_pop(input int id);
        case (id)
            0:       void'(q_a.pop_front());
            1:       void'(q_b.pop_front());
            default: void'(q_c.pop_front());
        endcase
    endtask

    task automatic q_flush(input int id);
        case (id)
            0:       q_a.delete();
            1:       q_b.delete();
            default: q_c.delete();
        endcase
    endtask

    // Mid-cycle observation of one DUT: every stall cycle adds exactly one
    // cycle to the latency of every item in flight.
    task automatic mon(input int id, input int lat, input int dw,
                       input logic iv, input logic ir, input logic [127:0] din, input int sel,
                       input logic ov, input logic ordy, input logic [7:0] dout);
        item_t it;
        string p;
        p = (id == 0) ? "a" : (id == 1) ? "b" : "c";
        cyc[id]++;
        if (!rst_n) begin
            q_flush(id);
            check_eq({p, "_rst_out_valid"}, 128'(ov), 128'(0));
            check_eq({p, "_rst_out_data"}, 128'(dout), 128'(0));
            check_eq({p, "_rst_in_ready"}, 128'(ir), 128'(1));
            hold[id] = 1'b0;
            return;
        end
        check_eq({p, "_in_ready"}, 128'(ir), 128'(!ov || ordy));
        if (hold[id]) begin
            check_eq({p, "_hold_valid"}, 128'(ov), 128'(1));
            check_eq({p, "_hold_data"}, 128'(dout), 128'(hold_data[id]));
        end
        if (ov) begin
            if (q_size(id) == 0) begin
                check_eq({p, "_spurious_valid"}, 128'(ov), 128'(0));
            end else begin
                it = q_front(id);
                check_eq({p, "_data"}, 128'(dout), 128'(it.data));
                if (ordy) begin
                    check_eq({p, "_latency"}, 128'(cyc[id] - it.cyc),
                             128'(lat + stalls[id] - it.stalls));
                    q_pop(id);
                end
            end
        end
        if (iv && ir) begin
            it.data   = ref_sel(din, sel, dw);
            it.cyc    = cyc[id];
            it.stalls = stalls[id];
            q_push(id, it);
        end
        hold[id]      = ov && !ordy;
        hold_data[id] = dout;
        if (ov && !ordy) stalls[id]++;
    endtask

    always @(negedge clk) begin
        mon(0, 3, 8, a_in_valid, a_in_ready, {64'b0, a_in_data}, int'(a_in_sel),
            a_out_valid, a_out_ready, a_out_data);
        mon(1, 1, 1, b_in_valid, b_in_ready, {126'b0, b_in_data}, int'(b_in_sel),
            b_out_valid, b_out_ready, {7'b0, b_out_data});
        mon(2, 5, 4, c_in_valid, c_in_ready, c_in_data, int'(c_in_sel),
            c_out_valid, c_out_ready, {4'b0, c_out_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds one item on the A inputs until the pipe takes it.
    task automatic send_a(input logic [63:0] d, input logic [2:0] s);
        logic acc;
        int   n;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_sel   = s;
        n = 0;
        do begin
            #1 acc = a_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check_eq("a_send_timeout", 128'(0), 128'(1));
    endtask

    task automatic rand_b();
        for (int i = 0; i < 400; i++) begin
            b_in_valid  = 1'($urandom_range(0, 3) != 0);
            b_in_data   = 2'($urandom);
            b_in_sel    = 1'($urandom);
            b_out_ready = (i < 200) ? 1'b1 : 1'($urandom);
            tick();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (10) tick();
        check_eq("b_drain", 128'(q_b.size()), 128'(0));
    endtask

    task automatic rand_c();
        for (int i = 0; i < 400; i++) begin
            c_in_valid  = 1'($urandom_range(0, 3) != 0);
            c_in_data   = {$urandom, $urandom, $urandom, $urandom};
            c_in_sel    = 5'($urandom);
            c_out_ready = (i < 200) ? 1'b1 : 1'($urandom);
            tick();
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        repeat (12) tick();
        check_eq("c_drain", 128'(q_c.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] sweep;
        logic [5:0]  bub;
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 0; stalls[i] = 0; hold[i] = 1'b0; hold_data[i] = '0;
        end
        a_in_data = '0; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        c_in_data = '0; c_in_sel = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_out_valid", 128'(a_out_valid), 128'(0));
        check_eq("reset_out_data", 128'(a_out_data), 128'(0));
        check_eq("reset_in_ready", 128'(a_in_ready), 128'(1));
        repeat (3) tick();
        rst_n = 1'b1;

        for (int c = 0; c < 8; c++) sweep[c*8 +: 8] = 8'(c * 8'h11);
        for (int s = 0; s < 8; s++) begin
            a_in_valid = 1'b1; a_in_data = sweep; a_in_sel = 3'(s);
            tick();
        end
        a_in_valid = 1'b0;
        repeat (6) tick();
        check_eq("a_sweep_drain", 128'(q_a.size()), 128'(0));

        send_a(64'h8000_0000_0000_0001, 3'd0);
        send_a(64'h8000_0000_0000_0001, 3'd7);
        a_in_valid = 1'b0;
        repeat (6) tick();
        check_eq("a_boundary_drain", 128'(q_a.size()), 128'(0));

        fork
            begin
                for (int i = 0; i < 6; i++) send_a({$urandom, $urandom}, 3'($urandom));
                a_in_valid = 1'b0;
            end
            begin
                repeat (4) tick();
                a_out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    #1;
                    check_eq("a_stall_in_ready", 128'(a_in_ready), 128'(0));
                    check_eq("a_stall_out_valid", 128'(a_out_valid), 128'(1));
                    tick();
                end
                a_out_ready = 1'b1;
            end
        join
        repeat (10) tick();
        check_eq("a_stall_drain", 128'(q_a.size()), 128'(0));

        bub = 6'b100101;
        for (int i = 0; i < 6; i++) begin
            a_in_valid = bub[i]; a_in_data = {$urandom, $urandom}; a_in_sel = 3'($urandom);
            tick();
        end
        a_in_valid = 1'b0;
        repeat (6) tick();
        check_eq("a_bubble_drain", 128'(q_a.size()), 128'(0));

        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_in_data = {$urandom, $urandom}; a_in_sel = 3'($urandom);
            tick();
        end
        a_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("a_async_rst_valid", 128'(a_out_valid), 128'(0));
        check_eq("a_async_rst_data", 128'(a_out_data), 128'(0));
        tick();
        rst_n = 1'b1;
        send_a({$urandom, $urandom}, 3'd5);
        a_in_valid = 1'b0;
        repeat (6) tick();
        check_eq("a_post_rst_drain", 128'(q_a.size()), 128'(0));

        fork
            rand_b();
            rand_c();
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
